d_e_reg: RTL and testbench

D/E pipeline register and E-stage operand selector for the five-stage MIPS core. Captures decoded D-stage fields on every clock edge, inserts a bubble when the hazard unit stalls, and drives the E-stage ALU with forwarded operands `E_data1`/`E_data2` and its 3-bit opcode `E_op`. Sits between the decode/register-file stage and the E-stage ALU. Also carries the destination and `Tnew` bookkeeping that the hazard unit and the E/M register consume.

---
 rtl/d_e_reg.sv | 90 +++++++++
 tb/tb_d_e_reg.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/d_e_reg.sv
// D/E pipeline register with E-stage operand forwarding.
// Bubbles on stall; operands are selected combinationally from M/W bypass data.
module d_e_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] D_pc,
    input  logic [31:0] D_instr,
    input  logic [31:0] D_rs_data,
    input  logic [31:0] D_rt_data,
    input  logic [31:0] D_ext,
    input  logic [2:0]  D_alu_op,
    input  logic        D_alusrc,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [4:0]  D_wa,
    input  logic [1:0]  D_tnew,
    input  logic [4:0]  M_wa,
    input  logic [31:0] M_wd,
    input  logic        M_fwd_ok,
    input  logic [4:0]  W_wa,
    input  logic [31:0] W_wd,
    output logic [31:0] E_pc,
    output logic [31:0] E_instr,
    output logic [4:0]  E_rs,
    output logic [4:0]  E_rt,
    output logic [4:0]  E_wa,
    output logic [1:0]  E_tnew,
    output logic [2:0]  E_op,
    output logic [31:0] E_rt_fwd,
    output logic [31:0] E_data1,
    output logic [31:0] E_data2
);

    localparam int unsigned DW = 32;

    logic [DW-1:0] rs_data_q;
    logic [DW-1:0] rt_data_q;
    logic [DW-1:0] ext_q;
    logic          alusrc_q;
    logic [DW-1:0] fwd_rs;

    // Reset and stall both load the all-zero bubble (sll $0,$0,0).
    always_ff @(posedge clk) begin
        if (reset || stall) begin
            E_pc      <= '0;
            E_instr   <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            ext_q     <= '0;
            E_op      <= '0;
            alusrc_q  <= 1'b0;
            E_rs      <= '0;
            E_rt      <= '0;
            E_wa      <= '0;
            E_tnew    <= '0;
        end else begin
            E_pc      <= D_pc;
            E_instr   <= D_instr;
            rs_data_q <= D_rs_data;
            rt_data_q <= D_rt_data;
            ext_q     <= D_ext;
            E_op      <= D_alu_op;
            alusrc_q  <= D_alusrc;
            E_rs      <= D_rs;
            E_rt      <= D_rt;
            E_wa      <= D_wa;
            E_tnew    <= D_tnew;
        end
    end

    // M wins over W; register 0 is never forwarded.
    always_comb begin
        fwd_rs   = rs_data_q;
        E_rt_fwd = rt_data_q;
        if (E_rs != 5'd0 && E_rs == M_wa && M_fwd_ok) begin
            fwd_rs = M_wd;
        end else if (E_rs != 5'd0 && E_rs == W_wa) begin
            fwd_rs = W_wd;
        end
        if (E_rt != 5'd0 && E_rt == M_wa && M_fwd_ok) begin
            E_rt_fwd = M_wd;
        end else if (E_rt != 5'd0 && E_rt == W_wa) begin
            E_rt_fwd = W_wd;
        end
        E_data1 = fwd_rs;
        E_data2 = alusrc_q ? ext_q : E_rt_fwd;
    end

endmodule

// File: tb/tb_d_e_reg.sv
// Directed self-checking bench for d_e_reg: capture, immediate select,
// forwarding priority, $0 guard, stall bubbles and reset.
module tb_d_e_reg;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic [31:0] D_pc, D_instr, D_rs_data, D_rt_data, D_ext;
    logic [2:0]  D_alu_op;
    logic        D_alusrc;
    logic [4:0]  D_rs, D_rt, D_wa;
    logic [1:0]  D_tnew;
    logic [4:0]  M_wa, W_wa;
    logic [31:0] M_wd, W_wd;
    logic        M_fwd_ok;
    logic [31:0] E_pc, E_instr, E_rt_fwd, E_data1, E_data2;
    logic [4:0]  E_rs, E_rt, E_wa;
    logic [1:0]  E_tnew;
    logic [2:0]  E_op;

    int n_cmp = 0;
    int n_err = 0;

    d_e_reg dut (
        .clk(clk), .reset(reset), .stall(stall),
        .D_pc(D_pc), .D_instr(D_instr), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
        .D_ext(D_ext), .D_alu_op(D_alu_op), .D_alusrc(D_alusrc),
        .D_rs(D_rs), .D_rt(D_rt), .D_wa(D_wa), .D_tnew(D_tnew),
        .M_wa(M_wa), .M_wd(M_wd), .M_fwd_ok(M_fwd_ok), .W_wa(W_wa), .W_wd(W_wd),
        .E_pc(E_pc), .E_instr(E_instr), .E_rs(E_rs), .E_rt(E_rt), .E_wa(E_wa),
        .E_tnew(E_tnew), .E_op(E_op), .E_rt_fwd(E_rt_fwd),
        .E_data1(E_data1), .E_data2(E_data2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0;
        D_pc = 32'hDEAD_BEEF; D_instr = 32'h1234_5678; D_rs_data = 32'h1111_1111;
        D_rt_data = 32'h2222_2222; D_ext = 32'h3333_3333; D_alu_op = 3'b100; D_alusrc = 1'b1;
        D_rs = 5'd4; D_rt = 5'd5; D_wa = 5'd6; D_tnew = 2'd2;
        M_wa = 5'd0; M_wd = 32'h0; M_fwd_ok = 1'b0; W_wa = 5'd0; W_wd = 32'h0;
        tick(); tick();
        n_cmp++; if (E_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", E_pc); end
        n_cmp++; if (E_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", E_instr); end
        n_cmp++; if ({E_rs, E_rt, E_wa} !== 15'h0) begin n_err++; $display("FAIL reset_regs got %h %h %h want 0", E_rs, E_rt, E_wa); end
        n_cmp++; if (E_tnew !== 2'd0) begin n_err++; $display("FAIL reset_tnew got %0d want 0", E_tnew); end
        n_cmp++; if (E_op !== 3'b000) begin n_err++; $display("FAIL reset_op got %b want 000", E_op); end
        n_cmp++; if (E_data1 !== 32'h0) begin n_err++; $display("FAIL reset_data1 got %h want 0", E_data1); end
        n_cmp++; if (E_data2 !== 32'h0) begin n_err++; $display("FAIL reset_data2 got %h want 0", E_data2); end
        n_cmp++; if (E_rt_fwd !== 32'h0) begin n_err++; $display("FAIL reset_rt_fwd got %h want 0", E_rt_fwd); end
        reset = 1'b0;
    endtask

    task automatic test_capture();
        D_pc = 32'h0000_3004; D_instr = 32'h0043_0822; D_rs_data = 32'd5; D_rt_data = 32'd7;
        D_ext = 32'h0; D_alu_op = 3'b001; D_alusrc = 1'b0; D_rs = 5'd2; D_rt = 5'd3;
        D_wa = 5'd1; D_tnew = 2'd1;
        tick();
        n_cmp++; if (E_pc !== 32'h0000_3004) begin n_err++; $display("FAIL cap_pc got %h want 00003004", E_pc); end
        n_cmp++; if (E_data1 !== 32'd5) begin n_err++; $display("FAIL cap_data1 got %h want 5", E_data1); end
        n_cmp++; if (E_data2 !== 32'd7) begin n_err++; $display("FAIL cap_data2 got %h want 7", E_data2); end
        n_cmp++; if (E_op !== 3'b001) begin n_err++; $display("FAIL cap_op got %b want 001", E_op); end
        n_cmp++; if (E_instr !== 32'h0043_0822) begin n_err++; $display("FAIL cap_instr got %h want 00430822", E_instr); end
        n_cmp++; if ({E_rs, E_rt, E_wa, E_tnew} !== {5'd2, 5'd3, 5'd1, 2'd1}) begin
            n_err++; $display("FAIL cap_fields got rs=%0d rt=%0d wa=%0d tnew=%0d want 2 3 1 1", E_rs, E_rt, E_wa, E_tnew);
        end
    endtask

    task automatic test_immediate();
        D_alusrc = 1'b1; D_ext = 32'h0000_1234; D_alu_op = 3'b011; D_rt_data = 32'd7;
        tick();
        n_cmp++; if (E_data2 !== 32'h0000_1234) begin n_err++; $display("FAIL imm_data2 got %h want 00001234", E_data2); end
        n_cmp++; if (E_rt_fwd !== 32'd7) begin n_err++; $display("FAIL imm_rt_fwd got %h want 7", E_rt_fwd); end
        n_cmp++; if (E_op !== 3'b011) begin n_err++; $display("FAIL imm_op got %b want 011", E_op); end
    endtask

    task automatic test_forward_priority();
        D_rs = 5'd8; D_rs_data = 32'h11; D_rt = 5'd8; D_rt_data = 32'h22; D_alusrc = 1'b0;
        tick();
        M_wa = 5'd8; M_wd = 32'hAA; M_fwd_ok = 1'b1; W_wa = 5'd8; W_wd = 32'hBB;
        #1;
        n_cmp++; if (E_data1 !== 32'hAA) begin n_err++; $display("FAIL fwd_m_data1 got %h want aa", E_data1); end
        n_cmp++; if (E_data2 !== 32'hAA) begin n_err++; $display("FAIL fwd_m_data2 got %h want aa", E_data2); end
        M_fwd_ok = 1'b0;
        #1;
        n_cmp++; if (E_data1 !== 32'hBB) begin n_err++; $display("FAIL fwd_w_data1 got %h want bb", E_data1); end
        n_cmp++; if (E_rt_fwd !== 32'hBB) begin n_err++; $display("FAIL fwd_w_rt_fwd got %h want bb", E_rt_fwd); end
        W_wa = 5'd9;
        #1;
        n_cmp++; if (E_data1 !== 32'h11) begin n_err++; $display("FAIL fwd_none_data1 got %h want 11", E_data1); end
        n_cmp++; if (E_data2 !== 32'h22) begin n_err++; $display("FAIL fwd_none_data2 got %h want 22", E_data2); end
        W_wa = 5'd0; M_wa = 5'd0;
    endtask

    task automatic test_zero_guard();
        D_rt = 5'd0; D_rt_data = 32'h0; D_rs = 5'd0; D_rs_data = 32'h55; D_alusrc = 1'b0;
        M_wa = 5'd0; M_wd = 32'hFFFF_FFFF; M_fwd_ok = 1'b1; W_wa = 5'd0; W_wd = 32'hBBBB;
        tick();
        n_cmp++; if (E_data2 !== 32'h0) begin n_err++; $display("FAIL zero_data2 got %h want 0", E_data2); end
        n_cmp++; if (E_data1 !== 32'h55) begin n_err++; $display("FAIL zero_data1 got %h want 55", E_data1); end
        M_fwd_ok = 1'b0; M_wd = 32'h0; W_wd = 32'h0;
    endtask

    task automatic test_stall_bubble();
        D_pc = 32'h0000_3010; D_instr = 32'h0043_0820; D_alu_op = 3'b000; D_rs = 5'd2;
        D_rt = 5'd3; D_wa = 5'd3; D_tnew = 2'd1; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if ({E_instr, E_wa, E_tnew, E_op} !== 42'h0) begin
                n_err++; $display("FAIL bubble%0d got instr=%h wa=%0d tnew=%0d op=%b want all 0", i, E_instr, E_wa, E_tnew, E_op);
            end
        end
        stall = 1'b0;
        tick();
        n_cmp++; if (E_instr !== 32'h0043_0820) begin n_err++; $display("FAIL unstall_instr got %h want 00430820", E_instr); end
        n_cmp++; if (E_wa !== 5'd3 || E_tnew !== 2'd1) begin n_err++; $display("FAIL unstall_wa_tnew got %0d %0d want 3 1", E_wa, E_tnew); end
        n_cmp++; if (E_pc !== 32'h0000_3010) begin n_err++; $display("FAIL unstall_pc got %h want 00003010", E_pc); end
    endtask

    task automatic test_reset_midstream();
        reset = 1'b1; stall = 1'b1;
        tick();
        n_cmp++; if ({E_pc, E_instr, E_wa, E_tnew} !== 71'h0) begin
            n_err++; $display("FAIL midreset got pc=%h instr=%h wa=%0d tnew=%0d want 0", E_pc, E_instr, E_wa, E_tnew);
        end
        reset = 1'b0; stall = 1'b0;
        tick();
        n_cmp++; if (E_wa !== 5'd3) begin n_err++; $display("FAIL post_reset_wa got %0d want 3", E_wa); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_immediate();
        test_forward_priority();
        test_zero_guard();
        test_stall_bubble();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
